// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit feeding the register-file
// write port. One radix-2 step per clock in CALC. Division by zero and signed
// overflow complete straight from IDLE.
// Optional macro FAST_MUL_EN: multiplies use a single-cycle combinational
// 32x32->64 multiplier and skip CALC. Divides are unchanged.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [ADDR_W-1:0] rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_we
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [4:0]          count_reg;
  logic [2:0]          funct3_reg;
  logic [2*XLEN-1:0]   acc_reg;     // product (mul) or {remainder, quotient} (div)
  logic [XLEN-1:0]     opnd_reg;    // |multiplicand| (mul) or |divisor| (div)
  logic                neg_reg;     // negate the selected result at the end
  logic [XLEN-1:0]     result_reg;
  logic [ADDR_W-1:0]   wb_rd_reg;

  // Operand decode of the incoming request
  logic              a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div0_in, ovf_in, direct_in;
  logic [XLEN-1:0]   direct_val_in;

  // Iterative step and final select
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_val;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   final_val;

`ifdef FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
`endif

  // Decode signedness, magnitudes and the cases that bypass CALC
  always_comb begin
    // MUL/MULH/MULHSU sign-extend a; MUL/MULH sign-extend b; DIV/REM both
    a_signed_in = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
    b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg_in    = a_signed_in & op_a[XLEN-1];
    b_neg_in    = b_signed_in & op_b[XLEN-1];
    mag_a_in    = a_neg_in ? (~op_a + 1'b1) : op_a;
    mag_b_in    = b_neg_in ? (~op_b + 1'b1) : op_b;
    // Remainder follows the dividend's sign; everything else the sign product
    neg_in      = (funct3[2] & funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

    div0_in = funct3[2] & (op_b == '0);
    ovf_in  = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}})
              & (op_b == '1);
    direct_in     = div0_in | ovf_in;
    direct_val_in = '0;
    if (div0_in)
      direct_val_in = funct3[1] ? op_a : '1;
    else if (ovf_in)
      direct_val_in = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

`ifdef FAST_MUL_EN
    fast_a    = {a_signed_in & op_a[XLEN-1], op_a};
    fast_b    = {b_signed_in & op_b[XLEN-1], op_b};
    fast_prod = fast_a * fast_b;
    if (!funct3[2]) begin
      direct_in     = 1'b1;
      direct_val_in = (funct3 == 3'b000) ? fast_prod[XLEN-1:0]
                                         : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One shift-add (mul) or restoring-subtract (div) step plus the final select
  always_comb begin
    // Multiply: acc low half holds the remaining multiplier bits
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
             + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_reg[XLEN-1:1]};
    // Divide: compare the shifted 33-bit partial remainder with the divisor
    div_diff = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opnd_reg};
    div_next = div_diff[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    step_val = funct3_reg[2] ? div_next : mul_next;

    prod_fix = neg_reg ? (~step_val + 1'b1) : step_val;
    div_sel  = funct3_reg[1] ? step_val[2*XLEN-1:XLEN] : step_val[XLEN-1:0];
    if (funct3_reg[2])
      final_val = neg_reg ? (~div_sel + 1'b1) : div_sel;
    else if (funct3_reg == 3'b000)
      final_val = prod_fix[XLEN-1:0];
    else
      final_val = prod_fix[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: if (start) state_next = direct_in ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (count_reg == 5'd31) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the request in IDLE, iterate in CALC, capture the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      funct3_reg <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
      wb_rd_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: if (start) begin
          count_reg  <= '0;
          funct3_reg <= funct3;
          wb_rd_reg  <= rd_in;
          neg_reg    <= neg_in;
          acc_reg    <= {{XLEN{1'b0}}, (funct3[2] ? mag_a_in : mag_b_in)};
          opnd_reg   <= funct3[2] ? mag_b_in : mag_a_in;
          if (direct_in) result_reg <= direct_val_in;
        end
        CALC: begin
          acc_reg   <= step_val;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) result_reg <= final_val;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign wb_rd  = wb_rd_reg;
  assign wb_we  = done & (wb_rd_reg != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, write enable,
// special cases, mid-operation reset and start-while-busy.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  wb_rd;

  int tests = 0;
  int fails = 0;
  int edges;
  int done_seen;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .wb_rd(wb_rd), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, count edges from the start edge (edge 1) to done high
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, {32'h0, result}, {32'h0, exp});
    check({tag, "_wb_rd"}, {59'h0, wb_rd}, {59'h0, rd});
    check({tag, "_wb_we"}, {63'h0, wb_we}, {63'h0, (rd != 5'd0)});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'h0, done, busy}, 64'h0);
    $display("[TB] %s f=%0d a=%h b=%h -> %h lat=%0d", tag, f, a, b, result, n);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, wb_we, wb_rd, result}, 64'h0);
    @(negedge clk) rst = 1'b1;

    // Multiplies
    run_op("mul_neg",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulh_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, MUL_LAT);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8, 32'hFFFFFFFF, MUL_LAT);

    // Divides
    run_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 33);
    run_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 33);
    run_op("divu_100", 3'b101, 32'd100,      32'd7, 5'd3, 32'd14,       33);
    run_op("remu_100", 3'b111, 32'd100,      32'd7, 5'd4, 32'd2,        33);

    // Special cases resolved without iteration
    run_op("div_by0",  3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
    run_op("remu_by0", 3'b111, 32'd5,        32'd0,        5'd11, 32'd5,        1);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1);

    // Reset in the middle of a DIVU (count has reached 10)
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", {63'h0, busy}, 64'h1);
    rst = 1'b0;
    #1;
    check("abort_outputs", {busy, done, wb_we, result}, 64'h0);
    @(negedge clk) rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || wb_we) done_seen++;
    end
    check("abort_no_write", 64'(done_seen), 64'h0);
    run_op("divu_reissue", 3'b101, 32'd1000, 32'd3, 5'd14, 32'd333, 33);

    // Start pulsed during CALC must be ignored
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    repeat (4) begin @(posedge clk); #1; edges++; end
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    edges++;
    while (!done && edges < 100) begin @(posedge clk); #1; edges++; end
    check("ignore_lat",    64'(edges), 64'd33);
    check("ignore_result", {32'h0, result}, 64'd14);
    check("ignore_wb_rd",  {59'h0, wb_rd}, 64'd5);
    $display("[TB] ignore_start result=%h wb_rd=%0d lat=%0d", result, wb_rd, edges);
    @(posedge clk); #1;

    // rd=0 suppresses the write; multiply latency depends on FAST_MUL_EN
    run_op("mul_rd0",  3'b000, 32'd3,   32'd4, 5'd0, 32'd12, MUL_LAT);
    run_op("divu_rd0", 3'b101, 32'd100, 32'd7, 5'd0, 32'd14, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
